// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver (LSB first, idle-high line).
// The rx pin passes through a two-flop synchroniser. The FSM samples each bit
// at mid-bit and presents good frames on a valid/ready byte port.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit after
// the data bits. When the macro is undefined, parity_err is tied to 0.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_e;

  state_e                 state_q;
  logic                   rx_meta_q;
  logic                   rx_s_q;
  logic [CW-1:0]          baud_cnt_q;
  logic [BW-1:0]          bit_idx_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [DATA_BITS-1:0]   m_data_q;
  logic                   m_valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                   parity_q;
  logic                   parity_err_q;
`endif

  // Two-flop synchroniser for the asynchronous rx pin; resets to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM plus the output holding register.
  // Handshake: a byte transfers on any edge where m_valid & m_ready are both 1;
  // m_data stays stable while m_valid=1 and no transfer has happened. A commit
  // on the same edge as a transfer refills the register with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Consumer takes the byte; a commit below may immediately refill it.
      if (m_valid_q && m_ready) m_valid_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q    <= S_START;
            baud_cnt_q <= '0;
          end
        end
        S_START: begin
          if (baud_cnt_q == CNT_HALF) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            // A start bit that is gone by mid-bit is a glitch: drop silently.
            state_q    <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt_q == CNT_LAST) begin
            baud_cnt_q <= '0;
            shreg_q    <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q   <= S_PARITY;
`else
              state_q   <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (baud_cnt_q == CNT_LAST) begin
            baud_cnt_q <= '0;
            parity_q   <= rx_s_q;
            state_q    <= S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_STOP: begin
          if (baud_cnt_q == CNT_LAST) begin
            baud_cnt_q <= '0;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HI;
            end
`ifdef UART_RX_PARITY_EN
            else if (^{parity_q, shreg_q}) begin
              parity_err_q <= 1'b1;
              state_q      <= S_IDLE;
            end
`endif
            else begin
              state_q <= S_IDLE;
              if (!m_valid_q || m_ready) begin
                m_data_q  <= shreg_q;
                m_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        S_WAIT_HI: begin
          // A held-low (break) line must return high before a new frame.
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench for uart_rx_core (16 clocks/bit, 8 data bits).
module tb_uart_rx_core;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Edge index (edge 0 = first edge registering rx=0) at which m_valid rises.
  localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB + PB * CPB;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx = 1'b1;
  logic          m_ready = 1'b1;
  logic          rand_ready = 1'b0;
  logic [DB-1:0] m_data;
  logic          m_valid;
  logic          busy;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  int            hs_cnt = 0;
  int            ferr_cnt = 0;
  int            ovr_cnt = 0;
  int            perr_cnt = 0;
  logic [DB-1:0] last_data = '0;
  logic [DB-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic step();
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hold_bit(input logic b);
    rx = b;
    for (int i = 0; i < CPB; i++) step();
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b);
    hold_bit(1'b0);
    for (int i = 0; i < DB; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(^d);
`endif
    hold_bit(stop_b);
  endtask

  // ---------------- monitor: handshakes, pulses, hold stability ----------------
  initial begin
    logic [DB-1:0] prev_data;
    logic          prev_hold;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
          hs_cnt++;
          last_data = m_data;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got byte %0h expected none (t=%0t)", m_data, $time);
          end else begin
            chk("sb_data", m_data, exp_q.pop_front());
          end
        end
        if (frame_err)  ferr_cnt++;
        if (overrun)    ovr_cnt++;
        if (parity_err) perr_cnt++;
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    int            exp_hs;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main test ----------------
  initial begin
    int h0, f0, o0, p0, exp_ferr;
    logic [DB-1:0] d;
    logic [DB-1:0] five_a;
    logic          bad;

    vecs[0] = '{8'h5A, 1'b1, 1, 0};
    vecs[1] = '{8'h80, 1'b1, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 1, 0};
    vecs[3] = '{8'h55, 1'b0, 0, 1};
    vecs[4] = '{8'hFE, 1'b1, 1, 0};
    vecs[5] = '{8'h00, 1'b0, 0, 1};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_parity_err", parity_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // 1. Single frame 0xA5, exact m_valid timing
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("lat_pre_valid", m_valid, 0);
        chk("lat_pre_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", m_valid, 1);
        chk("lat_data", m_data, 8'hA5);
        chk("lat_busy_low", busy, 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid_drop", m_valid, 0);
      end
    join
    idle(4);
    chk("t1_ferr", ferr_cnt, 0);
    chk("t1_ovr", ovr_cnt, 0);
    chk("t1_perr", perr_cnt, 0);

    // Table-driven frames with m_ready=1
    for (int i = 0; i < 6; i++) begin
      h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      if (vecs[i].exp_hs != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      idle(8);
      chk("vec_hs", hs_cnt - h0, vecs[i].exp_hs);
      chk("vec_ferr", ferr_cnt - f0, vecs[i].exp_ferr);
      chk("vec_ovr", ovr_cnt - o0, 0);
      chk("vec_busy", busy, 0);
      if (vecs[i].exp_hs != 0) chk("vec_data", last_data, vecs[i].data);
    end

    // 2. Back-to-back 0x00 then 0xFF
    h0 = hs_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(6);
    chk("b2b_hs", hs_cnt - h0, 2);
    chk("b2b_ovr", ovr_cnt - o0, 0);
    chk("b2b_last", last_data, 8'hFF);

    // 3. Overrun with m_ready=0
    h0 = hs_cnt; o0 = ovr_cnt;
    m_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_valid", m_valid, 1);
    chk("ovr_data", m_data, 8'h11);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    chk("ovr_drain", m_valid, 0);
    chk("ovr_hs", hs_cnt - h0, 1);
    @(posedge clk);
    #1 m_ready = 1'b1;

    // 4. Start glitch: 4 low cycles
    h0 = hs_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rx = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    @(posedge clk);
    #1 idle(4);
    chk("glitch_hs", hs_cnt - h0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_valid", m_valid, 0);

    // 5. Frame 0x3C with stop=0, line held low 40 more cycles
    h0 = hs_cnt; f0 = ferr_cnt;
    d = 8'h3C;
    hold_bit(1'b0);
    for (int i = 0; i < DB; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(^d);
`endif
    hold_bit(1'b0);
    repeat (40) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("brk_busy_hi", busy, 1);
    chk("brk_ferr", ferr_cnt - f0, 1);
    @(posedge clk);
    #1 idle(5);
    chk("brk_busy_lo", busy, 0);
    chk("brk_ferr_once", ferr_cnt - f0, 1);
    chk("brk_hs", hs_cnt - h0, 0);
    chk("brk_valid", m_valid, 0);

    // 6. Reset mid-DATA of 0x5A with a byte pending, then 0xC3
    m_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    idle(4);
    chk("rst_pre_valid", m_valid, 1);
    five_a = 8'h5A;
    hold_bit(1'b0);
    hold_bit(five_a[0]);
    hold_bit(five_a[1]);
    rx = five_a[2];
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulses", {frame_err, overrun, parity_err}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    idle(5);
    h0 = hs_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(6);
    chk("post_rst_hs", hs_cnt - h0, 1);
    chk("post_rst_data", last_data, 8'hC3);
`ifdef UART_RX_PARITY_EN
    h0 = hs_cnt; p0 = perr_cnt;
    d = 8'hC3;
    hold_bit(1'b0);
    for (int i = 0; i < DB; i++) hold_bit(d[i]);
    hold_bit(~(^d));
    hold_bit(1'b1);
    idle(6);
    chk("par_err", perr_cnt - p0, 1);
    chk("par_hs", hs_cnt - h0, 0);
`endif

    // Randomized frames, random m_ready, reference model from frame list
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    exp_ferr = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      if (bad) exp_ferr++;
      else     exp_q.push_back(d);
      send_frame(d, !bad);
      idle(bad ? $urandom_range(4, 20) : $urandom_range(0, 20));
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    idle(200);
    chk("rand_ferr", ferr_cnt - f0, exp_ferr);
    chk("rand_ovr", ovr_cnt - o0, 0);
    chk("rand_perr", perr_cnt - p0, 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
